n64_ctrl_sniffer: RTL
=====================

// Module: n64_ctrl_sniffer
// PURPOSE
//   Passive sniffer for the N64 controller line. Decodes the console poll command
//   and the 32-bit controller reply (buttons, stick X/Y), then presents them with a valid strobe.
//   Matches the buttons against N_COMBO programmable in-game-routine (IGR) combos,
//   each with a hold-time requirement. Sits beside the video pipeline in the VCLK domain.
//   Its IGR hits drive the 16-bit-mode, de-blur and reset controls.
// PARAMETERS
//   CLK_DIV     12     VCLK cycles per measurement tick (~0.25us at ~48.7MHz); >=2
//   CNT_W       8      tick counter width; saturation = line-timeout
//   CMD_POLL    8'h01  command byte that is followed by a button reply
//   N_COMBO     4      number of IGR combo slots
//   HOLD_POLLS  3      consecutive matching polls needed to fire a combo (1..255)
// PORTS
//   VCLK        in   1             system clock, only clock
//   nRST        in   1             asynchronous active-low reset
//   CTRL_i      in   1             raw controller data line (async; open-drain, idle high)
//   combo_i     in   16*N_COMBO    combo k = combo_i[16k+15:16k], same bit order as btn_o
//   combo_en_i  in   N_COMBO       per-slot enable
//   btn_o       out  16            last valid buttons; reply bit0 (A) -> btn_o[15]
//   stick_x_o   out  8             last valid stick X; reply bits 16..23, MSB first
//   stick_y_o   out  8             last valid stick Y; reply bits 24..31, MSB first
//   data_vld_o  out  1             1-cycle pulse when btn/stick update
//   igr_hit_o   out  N_COMBO       1-cycle pulse per slot on combo fire
//   rx_err_o    out  1             1-cycle pulse on aborted frame (timeout/short reply)
// BEHAVIOUR
//   - Reset: all outputs 0; state IDLE; hold counters 0; all slots armed.
//   - Reset is asynchronous, so outputs clear immediately, even mid-frame.
//   - CTRL_i passes through a 2-FF synchroniser, then a history reg for edge detection.
//     Edges are evaluated every VCLK; edge-to-edge latency is 3 VCLK.
//   - The tick enable pulses once per CLK_DIV VCLK. cnt counts ticks since the last edge.
//     Any edge clears cnt; an edge wins over a same-cycle tick. cnt saturates at all-ones.
//   - posedge: low_len <= cnt.
//   - negedge: resolves the previous bit as bit = (low_len < cnt), i.e. low shorter than high -> 1.
//   - States:
//     IDLE: wait for cnt saturated with the line high; then go to CMD with bit count 0.
//       A negedge before saturation is ignored.
//     CMD: the first negedge starts bit 0 (nothing is resolved yet). Later negedges resolve
//       bits MSB first, so the 8th bit is resolved at the stop-bit negedge.
//       The stop-bit value is resolved at the next negedge and is discarded.
//       If cmd == CMD_POLL -> RSP, else -> IDLE (no err).
//     RSP: negedges resolve 32 reply bits into a shift reg. The 32nd resolves at the
//       reply-stop negedge, then EVAL.
//     EVAL (1 cycle): update btn/stick, pulse data_vld_o, run the combo logic -> IDLE.
//   - Timeout: cnt saturates while in CMD/RSP -> IDLE.
//     In RSP with >0 bits received this also pulses rx_err_o. No output is updated.
//   - Combo slot k: match = combo_en_i[k] && btn == combo_k (exact 16-bit compare).
//     On EVAL with match: hold_k++ (saturates). When hold_k reaches HOLD_POLLS and the
//     slot is armed, pulse igr_hit_o[k] in the cycle after EVAL and disarm the slot.
//     On EVAL without match: hold_k = 0 and re-arm. A hit fires once per continuous press.
//   - Several slots may fire in the same cycle. A slot disabled mid-hold clears at the next EVAL.
//   - combo_i/combo_en_i are sampled only at EVAL and may change at any time.
// TESTING (CLK_DIV=12, VCLK 48.68MHz; '0'=3us low/1us high, '1'=1us low/3us high)
//   T1 reset: assert nRST mid-RSP -> all outputs 0 within the same cycle; no data_vld_o after release.
//   T2 reply: poll 0x01 + reply A+Start, X=0x12, Y=0xEE -> data_vld_o once, btn_o=16'h9000,
//      stick_x_o=8'h12, stick_y_o=8'hEE.
//   T3 command: command 0x00 + 24-bit status reply -> no data_vld_o, no rx_err_o; next poll decodes normally.
//   T4 timeout: line held low for 80us after reply bit 10 -> rx_err_o pulse, btn_o unchanged;
//      next valid poll decodes.
//   T5 hold: combo0=16'h3030 enabled, HOLD_POLLS=3; 5 matching polls -> igr_hit_o[0] only after poll 3;
//      1 mismatching poll then 3 matching -> second pulse.
//   T6 slots: slots 0 and 2 set to the same combo -> both bits pulse in the same cycle;
//      combo_en_i[2]=0 -> only bit 0.

Source files
------------

// File: rtl/n64_ctrl_sniffer.sv
// Passive N64 controller-line sniffer: decodes poll command and 32-bit reply,
// publishes buttons/stick with a valid strobe and matches in-game-routine combos.
module n64_ctrl_sniffer #(
    parameter int unsigned CLK_DIV    = 12,
    parameter int unsigned CNT_W      = 8,
    parameter logic [7:0]  CMD_POLL   = 8'h01,
    parameter int unsigned N_COMBO    = 4,
    parameter int unsigned HOLD_POLLS = 3
) (
    input  logic                  VCLK,
    input  logic                  nRST,
    input  logic                  CTRL_i,
    input  logic [16*N_COMBO-1:0] combo_i,
    input  logic [N_COMBO-1:0]    combo_en_i,
    output logic [15:0]           btn_o,
    output logic [7:0]            stick_x_o,
    output logic [7:0]            stick_y_o,
    output logic                  data_vld_o,
    output logic [N_COMBO-1:0]    igr_hit_o,
    output logic                  rx_err_o
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StCmd, StRsp, StEval} state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, low_len_q, low_len_d;
    logic [5:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [31:0]          sr_q, sr_d;
    logic [15:0]          btn_q, btn_d;
    logic [7:0]           sx_q, sx_d, sy_q, sy_d;
    logic                 vld_q, vld_d, err_q, err_d;
    logic [N_COMBO-1:0]   hit_q, hit_d, armed_q, armed_d;
    logic [7:0]           hold_q [N_COMBO];
    logic [7:0]           hold_d [N_COMBO];

    logic tick, rise, fall, cnt_sat, bit_val;

    always_comb begin
        logic       match;
        logic [7:0] hold_nxt;
        match     = 1'b0;
        hold_nxt  = '0;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_d     = cmd_q;
        sr_d      = sr_q;
        btn_d     = btn_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        vld_d     = 1'b0;
        err_d     = 1'b0;
        hit_d     = '0;
        armed_d   = armed_q;
        hold_d    = hold_q;
        low_len_d = low_len_q;

        sync1_d = CTRL_i;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        rise    = sync2_q & ~hist_q;
        fall    = ~sync2_q & hist_q;

        tick  = (div_q == DivW'(CLK_DIV - 1));
        div_d = tick ? '0 : div_q + DivW'(1);

        cnt_sat = &cnt_q;
        cnt_d   = cnt_q;
        if (rise || fall) begin
            cnt_d = '0;
        end else if (tick && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (rise) begin
            low_len_d = cnt_q;
        end
        // Low phase shorter than high phase encodes a 1.
        bit_val = (low_len_q < cnt_q);

        unique case (state_q)
            StIdle: begin
                if (cnt_sat && hist_q && !fall) begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                end
            end
            StCmd: begin
                // bit_cnt 0: waiting for the first negedge; 1..8: data bits; 9: stop bit.
                if (cnt_sat && bit_cnt_q != 6'd0) begin
                    state_d = StIdle;
                end else if (fall) begin
                    if (bit_cnt_q == 6'd9) begin
                        state_d   = (cmd_q == CMD_POLL) ? StRsp : StIdle;
                        bit_cnt_d = '0;
                    end else begin
                        if (bit_cnt_q != 6'd0) begin
                            cmd_d = {cmd_q[6:0], bit_val};
                        end
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            StRsp: begin
                if (cnt_sat) begin
                    state_d = StIdle;
                    err_d   = (bit_cnt_q != 6'd0);
                end else if (fall) begin
                    sr_d      = {sr_q[30:0], bit_val};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd31) begin
                        state_d = StEval;
                    end
                end
            end
            StEval: begin
                btn_d   = sr_q[31:16];
                sx_d    = sr_q[15:8];
                sy_d    = sr_q[7:0];
                vld_d   = 1'b1;
                state_d = StIdle;
                for (int k = 0; k < int'(N_COMBO); k++) begin
                    match = combo_en_i[k] && (sr_q[31:16] == combo_i[16*k +: 16]);
                    if (match) begin
                        hold_nxt  = (hold_q[k] == 8'hFF) ? hold_q[k] : hold_q[k] + 8'd1;
                        hold_d[k] = hold_nxt;
                        if (armed_q[k] && hold_nxt >= 8'(HOLD_POLLS)) begin
                            hit_d[k]   = 1'b1;
                            armed_d[k] = 1'b0;
                        end
                    end else begin
                        hold_d[k]  = '0;
                        armed_d[k] = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StIdle;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            hist_q    <= 1'b1;
            div_q     <= '0;
            cnt_q     <= '0;
            low_len_q <= '0;
            bit_cnt_q <= '0;
            cmd_q     <= '0;
            sr_q      <= '0;
            btn_q     <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            hit_q     <= '0;
            armed_q   <= '1;
            for (int k = 0; k < int'(N_COMBO); k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            low_len_q <= low_len_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_q     <= cmd_d;
            sr_q      <= sr_d;
            btn_q     <= btn_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            hit_q     <= hit_d;
            armed_q   <= armed_d;
            for (int k = 0; k < int'(N_COMBO); k++) begin
                hold_q[k] <= hold_d[k];
            end
        end
    end

    assign btn_o      = btn_q;
    assign stick_x_o  = sx_q;
    assign stick_y_o  = sy_q;
    assign data_vld_o = vld_q;
    assign igr_hit_o  = hit_q;
    assign rx_err_o   = err_q;

endmodule
